// File: rtl/dem_element_driver.sv
// dem_element_driver
//
// Final stage of the DEM DAC. It sits after the three-layer switching-block
// tree and does three things:
//   - turns each of the eight tri-level leaves into a pair of unit-element
//     drive bits (p = drive to +ref, n = drive to -ref),
//   - checks every sample for consistency, and
//   - optionally counts how often each element is used.
//
// Consistency checks:
//   - Every leaf must be -1, 0 or +1. Any other value sets a sticky
//     per-element flag.
//   - The eight leaves must add up to the tree input seen TREE_LATENCY
//     cycles earlier. A mismatch gives a one-cycle pulse and bumps a
//     saturating counter.
//
// Optional feature (macro DEM_USAGE_CNT_EN):
//   - Defined: builds eight wrapping usage counters and the cnt_sel_i
//     read-out mux.
//   - Undefined: no usage counters exist, usage_cnt_o is tied to zero and
//     cnt_sel_i is ignored.
//
// INPUT_WIDTH normally comes from the switch-block package shared with the
// tree. It is kept as a plain parameter here so this file stands alone, and
// the integrating level overrides it with the package value.
//
// Parameters:
//   INPUT_WIDTH   signed width of the tree input and of each leaf
//   TREE_LATENCY  cycles from x_in_i to the matching leaves on leaf_i (1..15)
//   CNT_WIDTH     width of the usage counters and of the error counter
//
// Ports:
//   clk_i        single clock
//   reset_i      synchronous, active-high reset
//   x_in_i       sample driven into the tree input this cycle (signed)
//   leaf_i       leaf k at [k*INPUT_WIDTH +: INPUT_WIDTH], signed
//   clr_i        synchronous clear of sticky flags and counters
//   cnt_sel_i    selects which element's usage count appears on usage_cnt_o
//   elem_p_o     per-element drive to +ref (registered)
//   elem_n_o     per-element drive to -ref (registered)
//   out_valid_o  elem_*_o carry a real sample (registered)
//   illegal_o    sticky per-element illegal-leaf flags
//   sum_err_o    one-cycle pulse on a leaf-sum mismatch (registered)
//   err_cnt_o    saturating count of leaf-sum mismatches
//   usage_cnt_o  usage count of the selected element (combinational mux)

module dem_element_driver #(
  parameter int INPUT_WIDTH  = 4,
  parameter int TREE_LATENCY = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic signed [INPUT_WIDTH-1:0] x_in_i,
  input  logic [8*INPUT_WIDTH-1:0]      leaf_i,
  input  logic                          clr_i,
  input  logic [2:0]                    cnt_sel_i,
  output logic [7:0]                    elem_p_o,
  output logic [7:0]                    elem_n_o,
  output logic                          out_valid_o,
  output logic [7:0]                    illegal_o,
  output logic                          sum_err_o,
  output logic [CNT_WIDTH-1:0]          err_cnt_o,
  output logic [CNT_WIDTH-1:0]          usage_cnt_o
);

  // Three extra bits hold the sum of eight INPUT_WIDTH-bit signed values,
  // so the accumulator can never overflow.
  localparam int SUM_WIDTH = INPUT_WIDTH + 3;

  logic [3:0]                    fill_cnt;
  logic                          live;
  logic signed [INPUT_WIDTH-1:0] x_dly [TREE_LATENCY];
  logic signed [INPUT_WIDTH-1:0] x_d;
  logic signed [INPUT_WIDTH-1:0] leaf [8];
  logic [7:0]                    is_pos;
  logic [7:0]                    is_neg;
  logic [7:0]                    is_bad;
  logic signed [SUM_WIDTH-1:0]   leaf_sum;
  logic                          sum_mismatch;

  // The tree needs TREE_LATENCY cycles after reset before its leaves reflect
  // real samples. The fill counter tracks that warm-up and parks at its
  // limit, and "live" marks the cycles whose leaves are trustworthy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fill_cnt <= '0;
    end else if (!live) begin
      fill_cnt <= fill_cnt + 4'd1;
    end
  end

  assign live = (fill_cnt == 4'(TREE_LATENCY));

  // The delay line mirrors the tree latency, so its tail lines up with
  // leaf_i. It runs every cycle; only reset clears it. clr_i has no effect
  // here.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < TREE_LATENCY; i++) begin
        x_dly[i] <= '0;
      end
    end else begin
      x_dly[0] <= x_in_i;
      for (int i = 1; i < TREE_LATENCY; i++) begin
        x_dly[i] <= x_dly[i-1];
      end
    end
  end

  assign x_d = x_dly[TREE_LATENCY-1];

  // Unpack and classify the leaves, and form their sign-extended sum.
  // -1 is the all-ones pattern. Anything other than -1, 0 or +1 is illegal
  // and drives neither rail, so p and n can never both be high.
  always_comb begin
    leaf_sum = '0;
    is_pos   = '0;
    is_neg   = '0;
    is_bad   = '0;
    for (int k = 0; k < 8; k++) begin
      leaf[k]   = leaf_i[k*INPUT_WIDTH +: INPUT_WIDTH];
      is_pos[k] = (leaf[k] == INPUT_WIDTH'(1));
      is_neg[k] = (leaf[k] == '1);
      is_bad[k] = !is_pos[k] && !is_neg[k] && (leaf[k] != '0);
      leaf_sum  = leaf_sum + SUM_WIDTH'(leaf[k]);
    end
  end

  assign sum_mismatch = live && (leaf_sum != SUM_WIDTH'(x_d));

  // Registered element drive, valid flag and mismatch pulse.
  // On warm-up cycles the drive bits load zero, so the elements stay idle
  // until real samples arrive.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      elem_p_o    <= '0;
      elem_n_o    <= '0;
      out_valid_o <= 1'b0;
      sum_err_o   <= 1'b0;
    end else begin
      elem_p_o    <= live ? is_pos : 8'h00;
      elem_n_o    <= live ? is_neg : 8'h00;
      out_valid_o <= live;
      sum_err_o   <= sum_mismatch;
    end
  end

  // Sticky illegal flags and the saturating mismatch counter.
  // A clear in the same cycle as a new event wins, and the event is dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      illegal_o <= '0;
      err_cnt_o <= '0;
    end else begin
      if (live) begin
        illegal_o <= illegal_o | is_bad;
      end
      if (sum_mismatch && (err_cnt_o != '1)) begin
        err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
      end
    end
  end

`ifdef DEM_USAGE_CNT_EN
  logic [CNT_WIDTH-1:0] usage_cnt [8];

  // One counter per element, bumped whenever that element is driven to
  // either rail on a live cycle. The counters wrap on purpose: mismatch
  // shaping characterisation only needs the differences between counts.
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      for (int k = 0; k < 8; k++) begin
        usage_cnt[k] <= '0;
      end
    end else if (live) begin
      for (int k = 0; k < 8; k++) begin
        if (is_pos[k] || is_neg[k]) begin
          usage_cnt[k] <= usage_cnt[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign usage_cnt_o = usage_cnt[cnt_sel_i];
`else
  logic unused_cnt_sel;

  assign usage_cnt_o    = '0;
  assign unused_cnt_sel = ^cnt_sel_i;
`endif

endmodule

// File: tb/tb_dem_element_driver.sv
// Testbench for dem_element_driver.
//
// A behavioural model follows the design's rules at sample level: a queue of
// past tree inputs, a count of cycles since reset, and integer arithmetic on
// the leaf values. The design is driven one cycle at a time, and every
// output is compared one time unit after the active edge.

module tb_dem_element_driver;

  localparam int W    = 4;
  localparam int L    = 3;
  localparam int C    = 8;
  localparam int CMAX = (1 << C) - 1;
  localparam int NRND = 200;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic signed [W-1:0] x_in_i;
  logic [8*W-1:0]      leaf_i;
  logic                clr_i;
  logic [2:0]          cnt_sel_i;
  logic [7:0]          elem_p_o;
  logic [7:0]          elem_n_o;
  logic                out_valid_o;
  logic [7:0]          illegal_o;
  logic                sum_err_o;
  logic [C-1:0]        err_cnt_o;
  logic [C-1:0]        usage_cnt_o;

  dem_element_driver #(
    .INPUT_WIDTH (W),
    .TREE_LATENCY(L),
    .CNT_WIDTH   (C)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .x_in_i     (x_in_i),
    .leaf_i     (leaf_i),
    .clr_i      (clr_i),
    .cnt_sel_i  (cnt_sel_i),
    .elem_p_o   (elem_p_o),
    .elem_n_o   (elem_n_o),
    .out_valid_o(out_valid_o),
    .illegal_o  (illegal_o),
    .sum_err_o  (sum_err_o),
    .err_cnt_o  (err_cnt_o),
    .usage_cnt_o(usage_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model state
  int         cur_lv [8];
  int         m_fill;
  int         m_hist [$];
  logic [7:0] exp_p;
  logic [7:0] exp_n;
  logic [7:0] exp_ill;
  logic       exp_valid;
  logic       exp_sum_err;
  int         exp_err;
  int         exp_usage [8];
  logic [2:0] cur_sel;

  function automatic logic [C-1:0] exp_usage_out();
`ifdef DEM_USAGE_CNT_EN
    return C'(exp_usage[cur_sel]);
`else
    return '0;
`endif
  endfunction

  // Drive one cycle of stimulus (x, the current cur_lv leaves, clr, reset,
  // select) and advance the model by one clock edge.
  task automatic drive_cycle(input int x, input logic clr, input logic rst,
                             input logic [2:0] sel);
    logic [31:0] tmp;
    int          xd;
    int          s;
    logic        live;
    reset_i   = rst;
    clr_i     = clr;
    cnt_sel_i = sel;
    cur_sel   = sel;
    tmp       = x;
    x_in_i    = tmp[W-1:0];
    for (int k = 0; k < 8; k++) begin
      tmp = cur_lv[k];
      leaf_i[k*W +: W] = tmp[W-1:0];
    end
    if (rst) begin
      m_fill = 0;
      m_hist.delete();
      for (int i = 0; i < L; i++) m_hist.push_back(0);
      exp_p = '0; exp_n = '0; exp_valid = 1'b0; exp_sum_err = 1'b0;
      exp_ill = '0; exp_err = 0;
      for (int k = 0; k < 8; k++) exp_usage[k] = 0;
    end else begin
      live = (m_fill >= L);
      xd   = m_hist.pop_front();
      m_hist.push_back(x);
      s = 0; exp_p = '0; exp_n = '0;
      for (int k = 0; k < 8; k++) begin
        s += cur_lv[k];
        if (live && cur_lv[k] == 1)  exp_p[k] = 1'b1;
        if (live && cur_lv[k] == -1) exp_n[k] = 1'b1;
      end
      exp_valid   = live;
      exp_sum_err = live && (s != xd);
      if (clr) begin
        exp_ill = '0;
        exp_err = 0;
        for (int k = 0; k < 8; k++) exp_usage[k] = 0;
      end else if (live) begin
        for (int k = 0; k < 8; k++) begin
          if (cur_lv[k] > 1 || cur_lv[k] < -1) exp_ill[k] = 1'b1;
          if (cur_lv[k] == 1 || cur_lv[k] == -1)
            exp_usage[k] = (exp_usage[k] + 1) % (CMAX + 1);
        end
        if (s != xd && exp_err < CMAX) exp_err++;
      end
      if (m_fill < L) m_fill++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic zero_leaves();
    for (int k = 0; k < 8; k++) cur_lv[k] = 0;
  endtask

  task automatic idle(input int n);
    zero_leaves();
    for (int i = 0; i < n; i++) drive_cycle(0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic test_reset();
    zero_leaves();
    drive_cycle(0, 1'b0, 1'b1, 3'd0);
    drive_cycle(0, 1'b0, 1'b1, 3'd0);
    checks += 7;
    if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0h expected 0", out_valid_o); end
    if (elem_p_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_p: got %0h expected 0", elem_p_o); end
    if (elem_n_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_n: got %0h expected 0", elem_n_o); end
    if (illegal_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_ill: got %0h expected 0", illegal_o); end
    if (sum_err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_sumerr: got %0h expected 0", sum_err_o); end
    if (err_cnt_o !== '0) begin errors++; $display("[TB] FAIL reset_errcnt: got %0h expected 0", err_cnt_o); end
    if (usage_cnt_o !== '0) begin errors++; $display("[TB] FAIL reset_usage: got %0h expected 0", usage_cnt_o); end
  endtask

  task automatic test_warmup();
    zero_leaves();
    for (int c = 1; c <= L + 2; c++) begin
      drive_cycle(0, 1'b0, 1'b0, 3'd0);
      checks++;
      if (out_valid_o !== (c >= L + 1)) begin
        errors++;
        $display("[TB] FAIL warmup_valid edge %0d: got %0h expected %0h", c, out_valid_o, (c >= L + 1));
      end
      checks++;
      if ((elem_p_o | elem_n_o) !== 8'h00) begin
        errors++;
        $display("[TB] FAIL warmup_elem edge %0d: got %0h/%0h expected 0", c, elem_p_o, elem_n_o);
      end
    end
  endtask

  task automatic test_balanced();
    idle(L);
    zero_leaves();
    drive_cycle(2, 1'b0, 1'b0, 3'd0);
    idle(L - 1);
    cur_lv = '{1, 1, 1, 1, 1, -1, -1, -1};
    drive_cycle(0, 1'b0, 1'b0, 3'd0);
    checks += 3;
    if (elem_p_o !== 8'h1F) begin errors++; $display("[TB] FAIL balanced_p: got %0h expected 1f", elem_p_o); end
    if (elem_n_o !== 8'hE0) begin errors++; $display("[TB] FAIL balanced_n: got %0h expected e0", elem_n_o); end
    if (sum_err_o !== 1'b0) begin errors++; $display("[TB] FAIL balanced_sumerr: got %0h expected 0", sum_err_o); end
  endtask

  task automatic test_sum_mismatch();
    zero_leaves();
    drive_cycle(0, 1'b1, 1'b0, 3'd0);
    idle(L - 1);
    drive_cycle(2, 1'b0, 1'b0, 3'd0);
    idle(L - 1);
    cur_lv = '{1, 1, 1, 1, 0, 0, 0, 0};
    drive_cycle(0, 1'b0, 1'b0, 3'd0);
    checks += 2;
    if (sum_err_o !== 1'b1) begin errors++; $display("[TB] FAIL mismatch_pulse: got %0h expected 1", sum_err_o); end
    if (err_cnt_o !== C'(1)) begin errors++; $display("[TB] FAIL mismatch_cnt: got %0h expected 1", err_cnt_o); end
    idle(1);
    checks += 2;
    if (sum_err_o !== 1'b0) begin errors++; $display("[TB] FAIL mismatch_pulse_end: got %0h expected 0", sum_err_o); end
    if (err_cnt_o !== C'(1)) begin errors++; $display("[TB] FAIL mismatch_cnt_hold: got %0h expected 1", err_cnt_o); end
    for (int k = 0; k < 8; k++) cur_lv[k] = 1;
    for (int i = 0; i < (1 << C) + 5; i++) drive_cycle(0, 1'b0, 1'b0, 3'd0);
    checks += 2;
    if (err_cnt_o !== C'(CMAX)) begin errors++; $display("[TB] FAIL mismatch_saturate: got %0h expected %0h", err_cnt_o, CMAX); end
    if (err_cnt_o !== C'(exp_err)) begin errors++; $display("[TB] FAIL mismatch_model: got %0h expected %0h", err_cnt_o, exp_err); end
  endtask

  task automatic test_illegal();
    zero_leaves();
    drive_cycle(0, 1'b1, 1'b0, 3'd0);
    idle(L);
    cur_lv[3] = 2;
    drive_cycle(0, 1'b0, 1'b0, 3'd0);
    checks += 2;
    if ({elem_p_o[3], elem_n_o[3]} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL illegal_drive: got p=%0h n=%0h expected 0", elem_p_o[3], elem_n_o[3]);
    end
    if (illegal_o !== 8'h08) begin errors++; $display("[TB] FAIL illegal_flag: got %0h expected 08", illegal_o); end
    idle(2);
    checks++;
    if (illegal_o !== 8'h08) begin errors++; $display("[TB] FAIL illegal_sticky: got %0h expected 08", illegal_o); end
    cur_lv[3] = 2;
    drive_cycle(0, 1'b1, 1'b0, 3'd0);
    checks++;
    if (illegal_o !== 8'h00) begin errors++; $display("[TB] FAIL illegal_clr_wins: got %0h expected 00", illegal_o); end
    idle(1);
    checks++;
    if (illegal_o !== 8'h00) begin errors++; $display("[TB] FAIL illegal_after_clr: got %0h expected 00", illegal_o); end
  endtask

  task automatic test_usage();
    logic [C-1:0] want10;
    logic [C-1:0] wantmax;
`ifdef DEM_USAGE_CNT_EN
    want10  = C'(10);
    wantmax = C'(CMAX);
`else
    want10  = '0;
    wantmax = '0;
`endif
    zero_leaves();
    drive_cycle(0, 1'b1, 1'b0, 3'd5);
    for (int i = 0; i < L; i++) drive_cycle(-1, 1'b0, 1'b0, 3'd5);
    cur_lv[5] = -1;
    for (int i = 0; i < 10; i++) drive_cycle(-1, 1'b0, 1'b0, 3'd5);
    checks += 3;
    if (usage_cnt_o !== want10) begin errors++; $display("[TB] FAIL usage_ten: got %0h expected %0h", usage_cnt_o, want10); end
    if (elem_n_o !== 8'h20) begin errors++; $display("[TB] FAIL usage_elem_n: got %0h expected 20", elem_n_o); end
    if (sum_err_o !== 1'b0) begin errors++; $display("[TB] FAIL usage_sumerr: got %0h expected 0", sum_err_o); end
    for (int i = 0; i < (1 << C) - 11; i++) drive_cycle(-1, 1'b0, 1'b0, 3'd5);
    checks++;
    if (usage_cnt_o !== wantmax) begin errors++; $display("[TB] FAIL usage_max: got %0h expected %0h", usage_cnt_o, wantmax); end
    drive_cycle(-1, 1'b0, 1'b0, 3'd5);
    checks++;
    if (usage_cnt_o !== '0) begin errors++; $display("[TB] FAIL usage_wrap: got %0h expected 0", usage_cnt_o); end
    drive_cycle(-1, 1'b0, 1'b0, 3'd2);
    checks++;
    if (usage_cnt_o !== '0) begin errors++; $display("[TB] FAIL usage_other_sel: got %0h expected 0", usage_cnt_o); end
  endtask

  task automatic test_random();
    int plan   [NRND][8];
    int plan_x [NRND];
    int r;
    int s;
    for (int c = 0; c < NRND; c++) begin
      s = 0;
      for (int k = 0; k < 8; k++) begin
        r = int'($urandom_range(0, 2));
        plan[c][k] = r - 1;
        s += r - 1;
      end
      if (s == 8) begin plan[c][0] = 0; s = 7; end
      plan_x[c] = s;
      if ($urandom_range(0, 11) == 0) plan_x[c] = (s == 0) ? 1 : 0;
      if ($urandom_range(0, 11) == 0) begin
        r = int'($urandom_range(2, 7));
        if ($urandom_range(0, 1) == 1) r = -r;
        plan[c][$urandom_range(0, 7)] = r;
      end
    end
    for (int c = 0; c < NRND + L; c++) begin
      for (int k = 0; k < 8; k++) cur_lv[k] = (c >= L) ? plan[c-L][k] : 0;
      drive_cycle((c < NRND) ? plan_x[c] : 0, ($urandom_range(0, 15) == 0),
                  1'b0, 3'($urandom_range(0, 7)));
      checks += 7;
      if (out_valid_o !== exp_valid) begin errors++; $display("[TB] FAIL rnd_valid c%0d: got %0h expected %0h", c, out_valid_o, exp_valid); end
      if (elem_p_o !== exp_p) begin errors++; $display("[TB] FAIL rnd_p c%0d: got %0h expected %0h", c, elem_p_o, exp_p); end
      if (elem_n_o !== exp_n) begin errors++; $display("[TB] FAIL rnd_n c%0d: got %0h expected %0h", c, elem_n_o, exp_n); end
      if (sum_err_o !== exp_sum_err) begin errors++; $display("[TB] FAIL rnd_sumerr c%0d: got %0h expected %0h", c, sum_err_o, exp_sum_err); end
      if (illegal_o !== exp_ill) begin errors++; $display("[TB] FAIL rnd_ill c%0d: got %0h expected %0h", c, illegal_o, exp_ill); end
      if (err_cnt_o !== C'(exp_err)) begin errors++; $display("[TB] FAIL rnd_errcnt c%0d: got %0h expected %0h", c, err_cnt_o, exp_err); end
      if (usage_cnt_o !== exp_usage_out()) begin errors++; $display("[TB] FAIL rnd_usage c%0d: got %0h expected %0h", c, usage_cnt_o, exp_usage_out()); end
    end
  endtask

  task automatic test_reset_midstream();
    int edges;
    zero_leaves();
    cur_lv[2] = 3;
    cur_lv[6] = 1;
    drive_cycle(0, 1'b0, 1'b0, 3'd6);
    zero_leaves();
    drive_cycle(0, 1'b0, 1'b1, 3'd6);
    checks += 6;
    if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %0h expected 0", out_valid_o); end
    if ((elem_p_o | elem_n_o) !== 8'h00) begin errors++; $display("[TB] FAIL mid_elem: got %0h/%0h expected 0", elem_p_o, elem_n_o); end
    if (illegal_o !== 8'h00) begin errors++; $display("[TB] FAIL mid_ill: got %0h expected 0", illegal_o); end
    if (sum_err_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_sumerr: got %0h expected 0", sum_err_o); end
    if (err_cnt_o !== '0) begin errors++; $display("[TB] FAIL mid_errcnt: got %0h expected 0", err_cnt_o); end
    if (usage_cnt_o !== '0) begin errors++; $display("[TB] FAIL mid_usage: got %0h expected 0", usage_cnt_o); end
    edges = 0;
    while (out_valid_o !== 1'b1 && edges < 50) begin
      drive_cycle(0, 1'b0, 1'b0, 3'd0);
      edges++;
    end
    checks++;
    if (edges != L + 1) begin
      errors++;
      $display("[TB] FAIL mid_rewarm: got %0d edges expected %0d", edges, L + 1);
    end
  endtask

  initial begin
    reset_i   = 1'b1;
    clr_i     = 1'b0;
    x_in_i    = '0;
    leaf_i    = '0;
    cnt_sel_i = '0;
    test_reset();
    test_warmup();
    test_balanced();
    test_sum_mismatch();
    test_illegal();
    test_usage();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dem_element_driver.md
# dem_element_driver

Final DEM-DAC stage, downstream of the three-layer switching-block tree. Takes the eight leaf values from the tree and converts each one into tri-level unit-element drive bits. Checks every sample for consistency: each leaf must be legal, and the eight leaves must sum to the tree input from TREE_LATENCY cycles earlier. Optionally keeps per-element usage counters for mismatch-shaping characterisation.

## Interface

Parameters:
- INPUT_WIDTH, from lib_switchblock_pkg: signed width of the tree input and of each leaf.
- TREE_LATENCY, 3: cycles from x_in_i at the tree input to the matching leaves at leaf_i. Range 1..15.
- CNT_WIDTH, 16: width of the usage counters and the error counter.

Ports:
- clk_i  in  1  single clock.
- reset_i  in  1  synchronous, active-high reset.
- x_in_i  in  INPUT_WIDTH signed  same sample driven into the tree input this cycle.
- leaf_i  in  8*INPUT_WIDTH  leaf k at [k*INPUT_WIDTH +: INPUT_WIDTH], signed; leaf k is tree output k+1.
- clr_i  in  1  synchronous clear of sticky flags and counters.
- cnt_sel_i  in  3  selects the element whose usage count appears on usage_cnt_o.
- elem_p_o  out  8  drive element k to +ref.
- elem_n_o  out  8  drive element k to -ref.
- out_valid_o  out  1  elem_*_o carry a real sample.
- illegal_o  out  8  sticky per-element illegal-leaf flag.
- sum_err_o  out  1  one-cycle pulse on a sum mismatch.
- err_cnt_o  out  CNT_WIDTH  saturating count of sum mismatches.
- usage_cnt_o  out  CNT_WIDTH  usage count of the element selected by cnt_sel_i.

## Operation

- **Fill counter:** 0..TREE_LATENCY, cleared by reset and incremented each cycle until it reaches TREE_LATENCY. A cycle is *live* when the counter equals TREE_LATENCY.
- **Delay line:** TREE_LATENCY-deep, holds x_in_i and runs every cycle. Its tail, x_d, is aligned with leaf_i.
- **Per-leaf mapping** on live cycles, for each leaf k:
  - +1 → p=1, n=0.
  - −1 → p=0, n=1.
  - 0 → p=0, n=0.
  - Any other value → p=0, n=0, and illegal_o[k] is set.
- p and n are never both 1.
- **Sum check:** sign-extend the 8 leaves to INPUT_WIDTH+3 bits and add them. If the sum is not equal to sign-extended x_d on a live cycle, pulse sum_err_o and increment err_cnt_o. err_cnt_o saturates at all-ones.
- **Usage counters:** counter k increments on each live cycle where leaf k is +1 or −1. Counters wrap modulo 2^CNT_WIDTH. usage_cnt_o is a combinational mux of the selected counter.
- **Non-live cycles:** no mapping, checking or counting. elem_*_o load 0.
- **clr_i:** clears illegal_o, err_cnt_o and all usage counters. It does not touch the fill counter, the delay line or elem_*_o. If clr_i and an event occur in the same cycle, the clear wins and the event is lost.

## Timing

- **Reset values:** all outputs 0; the fill counter and the delay line are also 0.
- **Output latency:** elem_p_o, elem_n_o, out_valid_o and sum_err_o are registered, one cycle after the leaf_i they describe.
- **Valid timing:** out_valid_o first rises in the (TREE_LATENCY+1)th clock edge after the reset_i-low edge, then stays high.
- **Sticky flags:** illegal_o and err_cnt_o update on the edge after the offending leaf_i.
- **Reset mid-stream:** discards the fill and the delay line. out_valid_o drops on the reset edge and the warm-up repeats.
- **Width rule:** the sum accumulator is INPUT_WIDTH+3 bits and cannot overflow.

## Configuration

- **DEM_USAGE_CNT_EN defined:** the eight usage counters and the cnt_sel_i mux are built.
- **DEM_USAGE_CNT_EN undefined:**
  - No usage counters exist.
  - usage_cnt_o is tied to 0 and cnt_sel_i is ignored.
  - All other behaviour is identical.

## Test plan

- **Warm-up:** reset, then release with TREE_LATENCY=3 and legal leaves → out_valid_o low for 3 edges, high from the 4th; elem_*_o stay 0 until then.
- **Balanced mapping:** x_in_i=2, then 3 cycles later leaves {+1,+1,+1,+1,+1,−1,−1,−1} → next cycle elem_p_o=0x1F, elem_n_o=0xE0, sum_err_o=0.
- **Sum mismatch:** leaves summing to 4 against aligned x_d=2 → sum_err_o pulses once, err_cnt_o=1. Then force 2^CNT_WIDTH+5 mismatches → err_cnt_o holds at all-ones.
- **Illegal leaf:** leaf 3 = +2 → elem_p_o[3]=elem_n_o[3]=0, illegal_o=0x08 and it stays set. clr_i in a cycle with a new illegal leaf 3 → illegal_o=0x00.
- **Usage counters (with DEM_USAGE_CNT_EN):** 10 live cycles with leaf 5 = −1 and other leaves 0, cnt_sel_i=5 → usage_cnt_o=10. Preload near 2^CNT_WIDTH−1 → the counter wraps to 0.
- **Reset mid-stream:** assert reset_i for 1 cycle while live → all outputs 0 on the next edge, and out_valid_o returns only after TREE_LATENCY+1 further edges.
